sram_wb_arbiter: RTL
====================

SRAM_WB_ARBITER -- requirements
Module: sram_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, word-address width; addresses are [AW+1:2].
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles a granted transfer may wait for slave ack.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports m0_cyc_i/m1_cyc_i, input, 1, master cycle (m0 = instruction fetch, m1 = data).
REQ-006 SHALL have ports m0_stb_i/m1_stb_i, input, 1, master strobe.
REQ-007 SHALL have ports m0_adr_i/m1_adr_i, input, AW, master word address.
REQ-008 SHALL have ports m0_we_i/m1_we_i, input, 1, master write enable.
REQ-009 SHALL have ports m0_sel_i/m1_sel_i, input, 4, master byte selects.
REQ-010 SHALL have ports m0_dat_i/m1_dat_i, input, 32, master write data.
REQ-011 SHALL have ports m0_dat_o/m1_dat_o, output, 32, read data, both driven from s_dat_i.
REQ-012 SHALL have ports m0_ack_o/m1_ack_o, output, 1, transfer acknowledge.
REQ-013 SHALL have ports m0_err_o/m1_err_o, output, 1, one-cycle timeout error pulse.
REQ-014 SHALL have ports s_cyc_o, s_stb_o, s_we_o, output, 1 each, slave-side controls to the SRAM wrapper.
REQ-015 SHALL have ports s_adr_o, output, AW; s_sel_o, output, 4; s_dat_o, output, 32, slave address, selects and write data.
REQ-016 SHALL have ports s_dat_i, input, 32, and s_ack_i, input, 1, slave read data and acknowledge.

Function
REQ-017 SHALL implement FSM states IDLE, OWN0, OWN1; request reqN = mN_cyc_i & mN_stb_i.
REQ-018 In IDLE, SHALL move to OWN0/OWN1 next cycle for the sole requester; with both requesting, SHALL grant the master not served last (last_grant register).
REQ-019 In OWNx, SHALL drive s_cyc/stb/we/adr/sel/dat_o combinationally from master x; in IDLE, SHALL drive all s_* outputs to 0.
REQ-020 SHALL route s_ack_i combinationally to mx_ack_o only in OWNx; the non-owner ack SHALL be 0; s_ack_i in IDLE SHALL be ignored.
REQ-021 Latency: request at cycle N, s_stb_o at N+1, mx_ack_o with slave ack (N+2 for the 1-cycle SRAM wrapper).
REQ-022 On s_ack_i in OWNx: if the other master requests, SHALL go directly to OWN(other); else if reqx is still high, SHALL stay in OWNx; else SHALL go to IDLE; last_grant SHALL be set to x.
REQ-023 If the owner deasserts cyc or stb before ack (abort), SHALL go to IDLE next cycle; a stale ack arriving in IDLE SHALL be dropped, not routed.
REQ-024 SHALL count cycles in OWNx without s_ack_i (counter cleared on grant and on each ack); on reaching TIMEOUT, SHALL pulse mx_err_o for 1 cycle, clear the counter and go to IDLE.
REQ-025 Simultaneous s_ack_i and timeout in the same cycle: ack SHALL win and no error SHALL be issued.
REQ-026 The counter SHALL saturate and never wrap; width is clog2(TIMEOUT+1).

Reset
REQ-027 While rst_ni=0, SHALL hold state=IDLE, last_grant=1 (so m0 wins the first tie), counter=0, all ack/err/s_* outputs 0, asynchronously.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err; the first post-reset grant SHALL follow REQ-018.

Verification
REQ-029 Single m1 read adr=0x10: s_stb_o high at N+1 with adr 0x10; m1_ack_o at N+2 with m1_dat_o = SRAM word; m0_ack_o stays 0.
REQ-030 Both masters request every cycle from reset: grants alternate m0, m1, m0, m1; each master receives an ack every other transfer, with no starvation.
REQ-031 m1 write sel=4'b0011 while m0 idle, then m0 requests during the m1 ack cycle: arbiter goes OWN0 directly with no IDLE bubble; SRAM bytes 0-1 updated only.
REQ-032 m0 drops cyc one cycle after grant: IDLE next cycle; the stale SRAM ack is not seen on m0_ack_o or m1_ack_o.
REQ-033 Slave ack tied 0, TIMEOUT=15: m0_err_o pulses exactly once, 15 cycles after grant; arbiter returns to IDLE and a pending m1 request is then granted.
REQ-034 rst_ni pulled low in OWN1 before ack: all outputs 0 immediately; after release, a simultaneous request grants m0 first.

Source files
------------

// File: rtl/sram_wb_arbiter.sv
// -----------------------------------------------------------------------------
// sram_wb_arbiter
// Two-master Wishbone arbiter in front of a single SRAM wrapper slave.
// m0 is the instruction-fetch master, m1 the data master. Ties are broken in
// favour of the master that was not served last. A transfer that waits
// TIMEOUT cycles without a slave ack is abandoned with a one-cycle error
// pulse to its owner.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i     master N cycle, strobe, write enable
//   mN_adr_i  [AW-1:0]      master N word address (byte address bits AW+1:2)
//   mN_sel_i  [3:0]         master N byte selects
//   mN_dat_i  [31:0]        master N write data
//   mN_dat_o  [31:0]        read data (both masters see s_dat_i)
//   mN_ack_o                acknowledge, only toward the current owner
//   mN_err_o                one-cycle timeout error pulse
//   s_cyc_o/stb_o/we_o      slave controls, zero while idle
//   s_adr_o/sel_o/dat_o     slave address, selects, write data
//   s_dat_i, s_ack_i        slave read data and acknowledge
// -----------------------------------------------------------------------------
module sram_wb_arbiter #(
    parameter int AW      = 13,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [3:0]    s_sel_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q;
    logic          last_grant_q;   // 1: m1 was served last, so m0 wins a tie
    logic [CW-1:0] cnt_q;          // cycles the owner has waited for an ack
    logic [CW-1:0] cnt_inc_s;
    logic          m0_err_q;
    logic          m1_err_q;

    logic req0_s;
    logic req1_s;
    logic own_m1_s;
    logic own_req_s;
    logic oth_req_s;

    assign req0_s    = m0_cyc_i & m0_stb_i;
    assign req1_s    = m1_cyc_i & m1_stb_i;
    assign own_m1_s  = (state_q == OWN1);
    assign own_req_s = own_m1_s ? req1_s : req0_s;
    assign oth_req_s = own_m1_s ? req0_s : req1_s;

    // Saturating increment of the ack-wait counter; it never wraps.
    always_comb begin
        cnt_inc_s = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_inc_s = cnt_q + CW'(1);
        end else begin
            cnt_inc_s = cnt_q;
        end
    end

    // Arbitration FSM, timeout counter and registered error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= CW'(0);
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= CW'(0);
                    if (req0_s && req1_s) begin
                        state_q <= last_grant_q ? OWN0 : OWN1;
                    end else if (req0_s) begin
                        state_q <= OWN0;
                    end else if (req1_s) begin
                        state_q <= OWN1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN0, OWN1: begin
                    if (s_ack_i) begin
                        // An ack beats a timeout landing on the same cycle.
                        last_grant_q <= own_m1_s;
                        cnt_q        <= CW'(0);
                        if (oth_req_s) begin
                            state_q <= own_m1_s ? OWN0 : OWN1;
                        end else if (own_req_s) begin
                            state_q <= state_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (!own_req_s) begin
                        // Owner aborted; any ack still in flight lands in IDLE.
                        state_q <= IDLE;
                        cnt_q   <= CW'(0);
                    end else if (cnt_inc_s == CNT_MAX) begin
                        state_q  <= IDLE;
                        cnt_q    <= CW'(0);
                        m0_err_q <= ~own_m1_s;
                        m1_err_q <= own_m1_s;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CW'(0);
                end
            endcase
        end
    end

    // Slave-side mux and ack routing follow the current owner combinationally.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = AW'(0);
        s_sel_o  = 4'd0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_err_o = m0_err_q;
    assign m1_err_o = m1_err_q;

endmodule
